// File: rtl/risc_pkg.sv
// Shared types and constants for the fetch stage: address/instruction widths,
// the fetch FSM state encoding and the PC incrementer.
package risc_pkg;

  localparam int ADDR_W = 10;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // Word-address increment; wraps modulo 2**ADDR_W with no carry out.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/ack channel between the fetch stage (master)
// and the instruction memory (slave).
interface inst_fetch_if;
  import risc_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding request, redirect handling and an
// output hold register. Optional stall counter under INST_FETCH_PERF_EN.
module inst_fetch
  import risc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 10'd0
) (
  input  logic              clk,
  input  logic              reset,
  inst_fetch_if.master      imem,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] instOut,
  output logic [ADDR_W-1:0] NPCOut,
  output logic              out_valid,
  input  logic              out_ready
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] stale_q, stale_d;
  logic              armed_q;
  logic              capture;

  // armed_q keeps imem_req low in the first cycle after reset release, so a
  // late ack belonging to an abandoned request is never consumed.
  assign imem.imem_req  = armed_q && (state_q != ST_HOLD);
  assign imem.imem_addr = (state_q == ST_DRAIN) ? stale_q : pc_q;
  assign out_valid      = (state_q == ST_HOLD);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    capture = 1'b0;
    unique case (state_q)
      ST_REQ: begin
        if (armed_q) begin
          if (redirect) begin
            pc_d = redirect_pc;
            if (!imem.imem_ack) begin
              state_d = ST_DRAIN;
              stale_d = pc_q;
            end
          end else if (imem.imem_ack) begin
            capture = 1'b1;
            pc_d    = pc_inc(pc_q);
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (out_ready) begin
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (imem.imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      stale_q <= RESET_PC;
      armed_q <= 1'b0;
      instOut <= NOP_INST;
      NPCOut  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      armed_q <= 1'b1;
      if (capture) begin
        instOut <= imem.imem_data;
        NPCOut  <= pc_d;
      end
    end
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (state_q == ST_HOLD && !out_ready && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, multi-cycle
// corner sequences and a randomized run against a behavioural model.
module tb_inst_fetch;
  import risc_pkg::*;

  logic              clk = 1'b0;
  logic              reset, reset1;
  logic              redirect, redirect1;
  logic [ADDR_W-1:0] redirect_pc, redirect_pc1;
  logic              out_ready, out_ready1;
  logic [INST_W-1:0] inst0, inst1;
  logic [ADDR_W-1:0] npc0, npc1;
  logic              valid0, valid1;
`ifdef INST_FETCH_PERF_EN
  logic [15:0]       stall0, stall1;
`endif

  int n_pass = 0;
  int n_total = 0;

  inst_fetch_if imem0 ();
  inst_fetch_if imem1 ();

  inst_fetch dut0 (
    .clk(clk), .reset(reset), .imem(imem0.master),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instOut(inst0), .NPCOut(npc0), .out_valid(valid0), .out_ready(out_ready)
`ifdef INST_FETCH_PERF_EN
    , .stall_cycles(stall0)
`endif
  );

  inst_fetch #(.RESET_PC(10'h3FF)) dut1 (
    .clk(clk), .reset(reset1), .imem(imem1.master),
    .redirect(redirect1), .redirect_pc(redirect_pc1),
    .instOut(inst1), .NPCOut(npc1), .out_valid(valid1), .out_ready(out_ready1)
`ifdef INST_FETCH_PERF_EN
    , .stall_cycles(stall1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic rd, input logic [ADDR_W-1:0] rpc, input logic ack, input logic rdy);
    redirect        = rd;
    redirect_pc     = rpc;
    imem0.imem_ack  = ack;
    imem0.imem_data = mem_word(imem0.imem_addr);
    out_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    imem0.imem_ack = 1'b0; imem0.imem_data = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] rpc;
    logic              ack;
    logic              rdy;
    logic              e_req;
    logic [ADDR_W-1:0] e_addr;
    logic              e_valid;
    logic [ADDR_W-1:0] e_npc;
  } vec_t;

  vec_t vecs [22];

  // Behavioural reference state for the randomized run.
  logic [ADDR_W-1:0] m_pc, m_stale_addr, m_npc;
  logic [INST_W-1:0] m_inst;
  logic              m_started, m_holding, m_stale;
  logic [15:0]       m_stall;

  initial begin
    //           rd  rpc     ack rdy  req addr    vld npc
    vecs[0]  = '{0, 10'h000, 0, 1,   1, 10'h000, 0, 10'h000};
    vecs[1]  = '{0, 10'h000, 0, 1,   1, 10'h000, 0, 10'h000};
    vecs[2]  = '{0, 10'h000, 1, 1,   0, 10'h000, 1, 10'h001};
    vecs[3]  = '{0, 10'h000, 0, 1,   1, 10'h001, 0, 10'h001};
    vecs[4]  = '{0, 10'h000, 0, 1,   1, 10'h001, 0, 10'h001};
    vecs[5]  = '{0, 10'h000, 1, 1,   0, 10'h000, 1, 10'h002};
    vecs[6]  = '{0, 10'h000, 0, 1,   1, 10'h002, 0, 10'h002};
    vecs[7]  = '{1, 10'h200, 0, 1,   1, 10'h002, 0, 10'h002};
    vecs[8]  = '{0, 10'h000, 0, 1,   1, 10'h002, 0, 10'h002};
    vecs[9]  = '{0, 10'h000, 1, 1,   1, 10'h200, 0, 10'h002};
    vecs[10] = '{0, 10'h000, 0, 1,   1, 10'h200, 0, 10'h002};
    vecs[11] = '{0, 10'h000, 1, 0,   0, 10'h000, 1, 10'h201};
    vecs[12] = '{1, 10'h050, 0, 1,   1, 10'h050, 0, 10'h201};
    vecs[13] = '{1, 10'h060, 1, 1,   1, 10'h060, 0, 10'h201};
    vecs[14] = '{0, 10'h000, 1, 0,   0, 10'h000, 1, 10'h061};
    vecs[15] = '{0, 10'h000, 0, 0,   0, 10'h000, 1, 10'h061};
    vecs[16] = '{0, 10'h000, 0, 1,   1, 10'h061, 0, 10'h061};
    vecs[17] = '{1, 10'h100, 0, 1,   1, 10'h061, 0, 10'h061};
    vecs[18] = '{1, 10'h180, 0, 1,   1, 10'h061, 0, 10'h061};
    vecs[19] = '{0, 10'h000, 1, 1,   1, 10'h180, 0, 10'h061};
    vecs[20] = '{0, 10'h000, 1, 1,   0, 10'h000, 1, 10'h181};
    vecs[21] = '{0, 10'h000, 0, 1,   1, 10'h181, 0, 10'h181};

    reset = 1'b0; reset1 = 1'b0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    redirect1 = 1'b0; redirect_pc1 = '0; out_ready1 = 1'b0;
    imem0.imem_ack = 1'b0; imem0.imem_data = '0;
    imem1.imem_ack = 1'b0; imem1.imem_data = '0;
    #12;
    check("rst_req",   32'(imem0.imem_req), 32'd0);
    check("rst_addr",  32'(imem0.imem_addr), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_npc",   32'(npc0), 32'd0);
    check("rst_inst",  inst0, NOP_INST);
    check("rst1_addr", 32'(imem1.imem_addr), 32'h3FF);

    // RESET_PC = 3FF: first NPCOut wraps to 0 and the next fetch is at 0.
    @(posedge clk); #1;
    reset1 = 1'b1;
    @(posedge clk); #1;
    check("wrap_req",  32'(imem1.imem_req), 32'd1);
    check("wrap_addr", 32'(imem1.imem_addr), 32'h3FF);
    imem1.imem_ack = 1'b1; imem1.imem_data = mem_word(10'h3FF);
    @(posedge clk); #1;
    imem1.imem_ack = 1'b0;
    check("wrap_valid", 32'(valid1), 32'd1);
    check("wrap_npc",   32'(npc1), 32'h000);
    check("wrap_inst",  inst1, mem_word(10'h3FF));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    check("wrap_next_req",  32'(imem1.imem_req), 32'd1);
    check("wrap_next_addr", 32'(imem1.imem_addr), 32'h000);

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].rd, vecs[i].rpc, vecs[i].ack, vecs[i].rdy);
      check($sformatf("vec%0d_req", i), 32'(imem0.imem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req)
        check($sformatf("vec%0d_addr", i), 32'(imem0.imem_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_valid", i), 32'(valid0), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_npc", i), 32'(npc0), 32'(vecs[i].e_npc));
      if (vecs[i].e_valid)
        check($sformatf("vec%0d_inst", i), inst0, mem_word(vecs[i].e_npc - 10'd1));
    end

    // Stall in HOLD for five cycles.
    do_reset();
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, '0, 0, 0);
      check("stall_valid", 32'(valid0), 32'd1);
      check("stall_req",   32'(imem0.imem_req), 32'd0);
      check("stall_npc",   32'(npc0), 32'd1);
      check("stall_inst",  inst0, mem_word(10'h000));
    end
`ifdef INST_FETCH_PERF_EN
    check("stall_count", 32'(stall0), 32'd5);
`endif
    step(0, '0, 0, 1);
    check("stall_release_valid", 32'(valid0), 32'd0);
    check("stall_release_addr",  32'(imem0.imem_addr), 32'd1);

    // Reset asserted while in DRAIN; a late ack after release is ignored.
    do_reset();
    step(0, '0, 0, 1);
    step(1, 10'h2A0, 0, 1);
    check("drain_addr", 32'(imem0.imem_addr), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_req",   32'(imem0.imem_req), 32'd0);
    check("async_addr",  32'(imem0.imem_addr), 32'd0);
    check("async_valid", 32'(valid0), 32'd0);
    check("async_npc",   32'(npc0), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, '0, 1, 1);
    check("late_ack_valid", 32'(valid0), 32'd0);
    check("late_ack_req",   32'(imem0.imem_req), 32'd1);
    check("late_ack_addr",  32'(imem0.imem_addr), 32'd0);
    step(0, '0, 0, 1);
    check("late_ack_valid2", 32'(valid0), 32'd0);

    // Randomized run against the behavioural model.
    do_reset();
    m_pc = '0; m_stale_addr = '0; m_npc = '0; m_inst = NOP_INST;
    m_started = 1'b0; m_holding = 1'b0; m_stale = 1'b0; m_stall = '0;
    for (int k = 0; k < 1500; k++) begin
      logic rd, ack, rdy;
      logic [ADDR_W-1:0] rpc, cur_addr;
      rd  = ($urandom_range(0, 99) < 15);
      rpc = ($urandom_range(0, 7) == 0) ? 10'h3FF : ADDR_W'($urandom);
      ack = m_started && !m_holding && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 99) < 60);
      cur_addr = m_stale ? m_stale_addr : m_pc;
      redirect = rd; redirect_pc = rpc; out_ready = rdy;
      imem0.imem_ack = ack; imem0.imem_data = mem_word(cur_addr);
      @(posedge clk);
      if (m_holding && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (!m_started) begin
        m_started = 1'b1;
      end else if (m_holding) begin
        if (rd) m_pc = rpc;
        if (rd || rdy) m_holding = 1'b0;
      end else if (m_stale) begin
        if (rd) m_pc = rpc;
        if (ack) m_stale = 1'b0;
      end else if (rd) begin
        if (!ack) begin
          m_stale = 1'b1;
          m_stale_addr = m_pc;
        end
        m_pc = rpc;
      end else if (ack) begin
        m_inst = mem_word(m_pc);
        m_npc = ADDR_W'((32'(m_pc) + 1) % 1024);
        m_pc = m_npc;
        m_holding = 1'b1;
      end
      #1;
      check("rnd_req",   32'(imem0.imem_req), 32'(m_started && !m_holding));
      if (m_started && !m_holding)
        check("rnd_addr", 32'(imem0.imem_addr), 32'(m_stale ? m_stale_addr : m_pc));
      check("rnd_valid", 32'(valid0), 32'(m_holding));
      check("rnd_npc",   32'(npc0), 32'(m_npc));
      check("rnd_inst",  inst0, m_inst);
`ifdef INST_FETCH_PERF_EN
      check("rnd_stall", 32'(stall0), 32'(m_stall));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
